// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary-to-binary converter: trit codes,
// FSM state encoding and width helpers.
package ternary_pkg;

   localparam int TRIT_W = 2;

   localparam logic [TRIT_W-1:0] TRIT_0   = 2'b00;
   localparam logic [TRIT_W-1:0] TRIT_1   = 2'b01;
   localparam logic [TRIT_W-1:0] TRIT_2   = 2'b10;
   localparam logic [TRIT_W-1:0] TRIT_BAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Binary width able to hold every value below 3^(n+1).
   function automatic int calc_w(input int n);
      longint unsigned p;
      int w;
      p = 64'd3;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd3;
      end
      w = 0;
      while ((64'd1 << w) < p) begin
         w++;
      end
      return w;
   endfunction

   // Trit counter width: ceil(log2(n+1)).
   function automatic int calc_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ternary_to_binary_converter_trit_mac.sv
// One Horner step: acc*3 + trit, flagging the illegal trit code.
module trit_mac
   import ternary_pkg::*;
#(
   parameter int W = 8
)(
   input  logic [W-1:0]      acc_i,
   input  logic [TRIT_W-1:0] trit_i,
   output logic [W-1:0]      acc_o,
   output logic              bad_o
);

   logic [W-1:0] digit;

   // Decode the trit (illegal code adds nothing) and multiply-accumulate.
   always_comb begin
      digit = '0;
      bad_o = 1'b0;
      case (trit_i)
         TRIT_1:   digit = W'(1);
         TRIT_2:   digit = W'(2);
         TRIT_BAD: bad_o = 1'b1;
         default:  digit = '0;
      endcase
      acc_o = (acc_i << 1) + acc_i + digit;
   end

endmodule

// File: rtl/ternary_to_binary_converter.sv
// Serial ternary-to-binary converter: latches a trit word plus carry,
// folds one trit per cycle MSB first, then holds the result until taken.
module ternary_to_binary_converter
   import ternary_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = calc_w(N)
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_sum,
   input  logic           in_cout,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_value,
   output logic           out_err
);

   localparam int               CNT_W    = calc_cnt_w(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_e              state_q, state_d;
   logic [2*N-1:0]      word_q, word_d;
   logic [W-1:0]        acc_q, acc_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TRIT_W-1:0]   trit_sel;
   logic [W-1:0]        mac_acc;
   logic                mac_bad;

   // Select the trit being folded: counter 0 picks trit N-1 (MSB first).
   always_comb begin
      trit_sel = TRIT_0;
      for (int k = 0; k < N; k++) begin
         if (int'(cnt_q) == N - 1 - k) begin
            trit_sel = word_q[TRIT_W*k +: TRIT_W];
         end
      end
   end

   trit_mac #(
      .W (W)
   ) u_trit_mac (
      .acc_i  (acc_q),
      .trit_i (trit_sel),
      .acc_o  (mac_acc),
      .bad_o  (mac_bad)
   );

   // Next-state logic for the IDLE -> CONV -> DONE handshake sequence.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      acc_d   = acc_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               word_d  = in_sum;
               acc_d   = W'(in_cout);
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            acc_d = mac_acc;
            err_d = err_q | mac_bad;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset clears everything including the latched word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_value = acc_q;
   assign out_err   = err_q;

endmodule
